// File: rtl/regfile_access_master.sv
// Command-driven initiator for the register file: owns read port 1 and
// shares write port 3 with the pipeline, which always wins the port.
module regfile_access_master #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    input  logic [AW-1:0] pipe_A3,
    input  logic [DW-1:0] pipe_WD3,
    input  logic          pipe_WE3,
    output logic [AW-1:0] rf_A1,
    input  logic [DW-1:0] rf_RD1,
    output logic [AW-1:0] rf_A3,
    output logic [DW-1:0] rf_WD3,
    output logic          rf_WE3,
    output logic          busy
);

    localparam logic [1:0]    OP_WRITE = 2'b00;
    localparam logic [1:0]    OP_READ  = 2'b01;
    localparam logic [1:0]    OP_DUMP  = 2'b10;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RSP,
        CLR
    } state_t;

    state_t        state, state_d;
    logic [AW-1:0] wr_addr, wr_addr_d;
    logic [DW-1:0] wr_data, wr_data_d;
    logic [AW-1:0] ptr, ptr_d;
    logic          dump, dump_d;
    logic [AW-1:0] a1_d;
    logic          rsp_valid_d, rsp_last_d;
    logic [AW-1:0] rsp_addr_d;
    logic [DW-1:0] rsp_data_d;
    logic          blk_we_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_addr   <= '0;
            wr_data   <= '0;
            ptr       <= '0;
            dump      <= 1'b0;
            rf_A1     <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
        end else begin
            state     <= state_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            ptr       <= ptr_d;
            dump      <= dump_d;
            rf_A1     <= a1_d;
            rsp_valid <= rsp_valid_d;
            rsp_addr  <= rsp_addr_d;
            rsp_data  <= rsp_data_d;
            rsp_last  <= rsp_last_d;
        end
    end

    // Next-state, next-datapath and block write request
    always_comb begin
        state_d     = state;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        ptr_d       = ptr;
        dump_d      = dump;
        a1_d        = rf_A1;
        rsp_valid_d = rsp_valid;
        rsp_addr_d  = rsp_addr;
        rsp_data_d  = rsp_data;
        rsp_last_d  = rsp_last;
        cmd_ready   = 1'b0;
        blk_we_c    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            wr_addr_d = cmd_addr;
                            wr_data_d = cmd_data;
                            state_d   = WR;
                        end
                        OP_READ: begin
                            a1_d    = cmd_addr;
                            dump_d  = 1'b0;
                            state_d = RD;
                        end
                        OP_DUMP: begin
                            a1_d    = '0;
                            dump_d  = 1'b1;
                            state_d = RD;
                        end
                        default: begin
                            ptr_d   = '0;
                            state_d = CLR;
                        end
                    endcase
                end
            end
            WR: begin
                if (!pipe_WE3) begin
                    blk_we_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD: begin
                rsp_data_d  = rf_RD1;
                rsp_addr_d  = rf_A1;
                rsp_last_d  = !dump || (rf_A1 == LAST_IDX);
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (dump && !rsp_last) begin
                        a1_d    = rf_A1 + AW'(1);
                        state_d = RD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CLR: begin
                // Pointer only moves on cycles the pipeline leaves the port free
                if (!pipe_WE3) begin
                    blk_we_c = 1'b1;
                    if (ptr == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write port mux: pipeline first, block only when the port is idle
    always_comb begin
        rf_A3  = pipe_A3;
        rf_WD3 = pipe_WD3;
        rf_WE3 = pipe_WE3;
        if (blk_we_c && !rst) begin
            rf_WE3 = 1'b1;
            rf_A3  = (state == CLR) ? ptr : wr_addr;
            rf_WD3 = (state == CLR) ? '0 : wr_data;
        end
    end

    assign busy = (state != IDLE);

endmodule
